// File: rtl/mcycle_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : mcycle_sequencer                                              |
// | Description : 8080 machine-cycle sequencer (opcode fetch, memory read,      |
// |               memory write). Walks T1..T5 with READY wait states and        |
// |               decodes latch, register-mux, PC-increment and bus strobes.    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module mcycle_sequencer #(
  parameter int FETCH_TSTATES = 4,
  parameter int MAX_WAIT      = 15
) (
  input  logic       clk50M_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [1:0] cyc_type_i,
  input  logic [2:0] addr_sel_i,
  input  logic [3:0] dst_sel_i,
  input  logic       ready_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [2:0] reg16_sel_o,
  output logic       latch_wr_o,
  output logic       latch_rd_o,
  output logic [3:0] reg8_sel_o,
  output logic       reg_read_o,
  output logic       reg_write_o,
  output logic       ir_load_o,
  output logic       pc_inc_o,
  output logic       sync_o,
  output logic       dbin_o,
  output logic       wr_n_o,
  output logic       wait_o
);

  localparam logic [2:0] c_S_IDLE = 3'd0;
  localparam logic [2:0] c_S_T1   = 3'd1;
  localparam logic [2:0] c_S_T2   = 3'd2;
  localparam logic [2:0] c_S_TW   = 3'd3;
  localparam logic [2:0] c_S_T3   = 3'd4;
  localparam logic [2:0] c_S_T4   = 3'd5;
  localparam logic [2:0] c_S_T5   = 3'd6;

  localparam logic [1:0] c_CYC_FETCH  = 2'b00;
  localparam logic [1:0] c_CYC_MEM_RD = 2'b01;
  localparam logic [1:0] c_CYC_MEM_WR = 2'b10;
  localparam logic [2:0] c_ADDR_PC    = 3'd4;

  // A zero MAX_WAIT still needs a one-bit counter so the vector is legal.
  localparam int                  c_WAIT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = (MAX_WAIT > 0) ? c_WAIT_W'(MAX_WAIT - 1) : '0;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [1:0]          r_type;
  logic [2:0]          r_addr;
  logic [3:0]          r_dst;
  logic                r_err;
  logic                w_err_nxt;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                w_legal;
  logic                w_final;
  logic                w_sample;
  logic                w_accept;
  logic                w_timeout;
  logic                w_bus;

  assign w_legal   = (cyc_type_i != 2'b11) && (addr_sel_i <= c_ADDR_PC);
  assign w_final   = ((r_state == c_S_T3) && (r_type != c_CYC_FETCH)) ||
                     ((r_state == c_S_T4) && (FETCH_TSTATES < 5)) ||
                     (r_state == c_S_T5);
  assign w_sample  = (r_state == c_S_IDLE) || w_final;
  assign w_accept  = w_sample && start_i && w_legal;
  // The last permitted TW cycle is the one where the counter already holds MAX_WAIT-1.
  assign w_timeout = (MAX_WAIT != 0) && (r_state == c_S_TW) && (r_wait_cnt == c_WAIT_LAST);
  assign w_bus     = (r_state == c_S_T2) || (r_state == c_S_TW) || (r_state == c_S_T3);

  // Next-state and error-pulse decision.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    if (w_sample) begin
      w_state_nxt = c_S_IDLE;
      if (start_i) begin
        if (w_legal) w_state_nxt = c_S_T1;
        else         w_err_nxt   = 1'b1;
      end
    end else begin
      case (r_state)
        c_S_T1:  w_state_nxt = c_S_T2;
        c_S_T2:  w_state_nxt = ready_i ? c_S_T3 : c_S_TW;
        c_S_TW: begin
          if (ready_i) begin
            w_state_nxt = c_S_T3;
          end else if (w_timeout) begin
            w_state_nxt = c_S_IDLE;
            w_err_nxt   = 1'b1;
          end
        end
        c_S_T3:  w_state_nxt = c_S_T4;
        c_S_T4:  w_state_nxt = c_S_T5;
        default: w_state_nxt = c_S_IDLE;
      endcase
    end
  end

  // State, error pulse and request fields; fields load only on an accepted
  // request so the address select held in IDLE is always a legal source.
  always_ff @(posedge clk50M_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= c_S_IDLE;
      r_err   <= 1'b0;
      r_type  <= c_CYC_FETCH;
      r_addr  <= c_ADDR_PC;
      r_dst   <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      if (w_accept) begin
        r_type <= cyc_type_i;
        r_addr <= addr_sel_i;
        r_dst  <= dst_sel_i;
      end
    end
  end

  // Wait-state counter: cleared in T1, counts TW cycles, saturates.
  always_ff @(posedge clk50M_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wait_cnt <= '0;
    end else if (r_state == c_S_T1) begin
      r_wait_cnt <= '0;
    end else if ((r_state == c_S_TW) && (r_wait_cnt != '1)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign reg16_sel_o = r_addr;
  assign err_o       = r_err;

  // Strobe decode from the registered state and captured fields.
  always_comb begin
    busy_o      = (r_state != c_S_IDLE);
    done_o      = w_final;
    latch_wr_o  = (r_state == c_S_T1);
    sync_o      = (r_state == c_S_T1);
    latch_rd_o  = w_bus;
    wait_o      = (r_state == c_S_TW);
    pc_inc_o    = (r_state == c_S_T2) && (r_addr == c_ADDR_PC) && (r_type != c_CYC_MEM_WR);
    dbin_o      = w_bus && (r_type != c_CYC_MEM_WR);
    reg_read_o  = w_bus && (r_type == c_CYC_MEM_WR);
    wr_n_o      = !((r_state == c_S_T3) && (r_type == c_CYC_MEM_WR));
    reg_write_o = (r_state == c_S_T3) && (r_type == c_CYC_MEM_RD);
    ir_load_o   = (r_state == c_S_T3) && (r_type == c_CYC_FETCH);
    reg8_sel_o  = 4'b0000;
    if (reg_read_o || reg_write_o) reg8_sel_o = r_dst;
  end

endmodule
`default_nettype wire

// File: tb/tb_mcycle_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_mcycle_sequencer                                           |
// | Description : Directed self-checking bench for mcycle_sequencer             |
// |               (FETCH_TSTATES=4, MAX_WAIT=3).                                |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_mcycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cyc_type = 2'b00;
  logic [2:0] addr_sel = 3'd0;
  logic [3:0] dst_sel = 4'd0;
  logic       ready = 1'b1;
  logic       busy, done, err, latch_wr, latch_rd, reg_read, reg_write;
  logic       ir_load, pc_inc, sync, dbin, wr_n, wait_s;
  logic [2:0] reg16_sel;
  logic [3:0] reg8_sel;

  int tests = 0;
  int fails = 0;

  // Packed view: busy done err sel16[3] lwr lrd sel8[4] rrd rwr ir pcinc sync dbin wr_n wait
  logic [19:0] outs;
  assign outs = {busy, done, err, reg16_sel, latch_wr, latch_rd, reg8_sel,
                 reg_read, reg_write, ir_load, pc_inc, sync, dbin, wr_n, wait_s};

  mcycle_sequencer #(.FETCH_TSTATES(4), .MAX_WAIT(3)) dut (
    .clk50M_i(clk), .rst_ni(rst_n), .start_i(start), .cyc_type_i(cyc_type),
    .addr_sel_i(addr_sel), .dst_sel_i(dst_sel), .ready_i(ready),
    .busy_o(busy), .done_o(done), .err_o(err), .reg16_sel_o(reg16_sel),
    .latch_wr_o(latch_wr), .latch_rd_o(latch_rd), .reg8_sel_o(reg8_sel),
    .reg_read_o(reg_read), .reg_write_o(reg_write), .ir_load_o(ir_load),
    .pc_inc_o(pc_inc), .sync_o(sync), .dbin_o(dbin), .wr_n_o(wr_n), .wait_o(wait_s)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [19:0] exp;
    repeat (2) @(negedge clk);
    exp = 20'b0_0_0_100_0_0_0000_0_0_0_0_0_0_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL reset_vals got=%b exp=%b", outs, exp); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (outs !== exp) begin fails++; $display("FAIL reset_release got=%b exp=%b", outs, exp); end
  endtask

  task automatic test_fetch();
    logic [19:0] exp;
    start = 1; cyc_type = 2'b00; addr_sel = 3'd4; dst_sel = 4'd0; ready = 1;
    @(negedge clk); start = 0;
    exp = 20'b1_0_0_100_1_0_0000_0_0_0_0_1_0_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL fetch_t1 got=%b exp=%b", outs, exp); end
    @(negedge clk);
    exp = 20'b1_0_0_100_0_1_0000_0_0_0_1_0_1_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL fetch_t2 got=%b exp=%b", outs, exp); end
    @(negedge clk);
    exp = 20'b1_0_0_100_0_1_0000_0_0_1_0_0_1_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL fetch_t3 got=%b exp=%b", outs, exp); end
    @(negedge clk);
    exp = 20'b1_1_0_100_0_0_0000_0_0_0_0_0_0_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL fetch_t4 got=%b exp=%b", outs, exp); end
    @(negedge clk);
    exp = 20'b0_0_0_100_0_0_0000_0_0_0_0_0_0_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL fetch_idle got=%b exp=%b", outs, exp); end
  endtask

  task automatic test_mem_rd_wait();
    logic [19:0] exp;
    start = 1; cyc_type = 2'b01; addr_sel = 3'd2; dst_sel = 4'd0; ready = 1;
    @(negedge clk); start = 0;
    exp = 20'b1_0_0_010_1_0_0000_0_0_0_0_1_0_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL rd_t1 got=%b exp=%b", outs, exp); end
    @(negedge clk);
    exp = 20'b1_0_0_010_0_1_0000_0_0_0_0_0_1_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL rd_t2 got=%b exp=%b", outs, exp); end
    ready = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp = 20'b1_0_0_010_0_1_0000_0_0_0_0_0_1_1_1;
      tests++; if (outs !== exp) begin fails++; $display("FAIL rd_tw%0d got=%b exp=%b", i, outs, exp); end
      ready = (i == 1);
    end
    @(negedge clk);
    exp = 20'b1_1_0_010_0_1_0000_0_1_0_0_0_1_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL rd_t3 got=%b exp=%b", outs, exp); end
    @(negedge clk);
    exp = 20'b0_0_0_010_0_0_0000_0_0_0_0_0_0_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL rd_idle got=%b exp=%b", outs, exp); end
    // MEM_RD from PC into L: PC increments and the mux selects code 0101.
    start = 1; cyc_type = 2'b01; addr_sel = 3'd4; dst_sel = 4'd5;
    @(negedge clk); start = 0;
    @(negedge clk);
    exp = 20'b1_0_0_100_0_1_0000_0_0_0_1_0_1_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL rdpc_t2 got=%b exp=%b", outs, exp); end
    @(negedge clk);
    exp = 20'b1_1_0_100_0_1_0101_0_1_0_0_0_1_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL rdpc_t3 got=%b exp=%b", outs, exp); end
    @(negedge clk);
  endtask

  task automatic test_mem_wr();
    logic [19:0] exp;
    start = 1; cyc_type = 2'b10; addr_sel = 3'd1; dst_sel = 4'd7; ready = 1;
    @(negedge clk); start = 0;
    exp = 20'b1_0_0_001_1_0_0000_0_0_0_0_1_0_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL wr_t1 got=%b exp=%b", outs, exp); end
    @(negedge clk);
    exp = 20'b1_0_0_001_0_1_0111_1_0_0_0_0_0_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL wr_t2 got=%b exp=%b", outs, exp); end
    @(negedge clk);
    exp = 20'b1_1_0_001_0_1_0111_1_0_0_0_0_0_0_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL wr_t3 got=%b exp=%b", outs, exp); end
    @(negedge clk);
    exp = 20'b0_0_0_001_0_0_0000_0_0_0_0_0_0_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL wr_idle got=%b exp=%b", outs, exp); end
  endtask

  task automatic test_timeout();
    logic [19:0] exp;
    start = 1; cyc_type = 2'b01; addr_sel = 3'd0; dst_sel = 4'd1; ready = 0;
    @(negedge clk); start = 0;
    @(negedge clk);
    exp = 20'b1_0_0_000_0_1_0000_0_0_0_0_0_1_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL to_t2 got=%b exp=%b", outs, exp); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = 20'b1_0_0_000_0_1_0000_0_0_0_0_0_1_1_1;
      tests++; if (outs !== exp) begin fails++; $display("FAIL to_tw%0d got=%b exp=%b", i, outs, exp); end
    end
    @(negedge clk);
    exp = 20'b0_0_1_000_0_0_0000_0_0_0_0_0_0_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL to_abort got=%b exp=%b", outs, exp); end
    @(negedge clk);
    exp = 20'b0_0_0_000_0_0_0000_0_0_0_0_0_0_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL to_err_clear got=%b exp=%b", outs, exp); end
    ready = 1;
  endtask

  task automatic test_illegal();
    start = 1; cyc_type = 2'b11; addr_sel = 3'd0;
    @(negedge clk); start = 0;
    tests++; if ({busy, err} !== 2'b01) begin fails++; $display("FAIL ill_type busy_err got=%b exp=01", {busy, err}); end
    @(negedge clk);
    tests++; if ({busy, err} !== 2'b00) begin fails++; $display("FAIL ill_type_after got=%b exp=00", {busy, err}); end
    start = 1; cyc_type = 2'b01; addr_sel = 3'd6;
    @(negedge clk); start = 0;
    tests++; if ({busy, err} !== 2'b01) begin fails++; $display("FAIL ill_addr busy_err got=%b exp=01", {busy, err}); end
    @(negedge clk);
    tests++; if ({busy, err} !== 2'b00) begin fails++; $display("FAIL ill_addr_after got=%b exp=00", {busy, err}); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp;
    start = 1; cyc_type = 2'b00; addr_sel = 3'd4; ready = 1;
    @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_fetch_done got=%b exp=1", done); end
    // Chain a MEM_WR from PC with H as source straight out of the done cycle.
    start = 1; cyc_type = 2'b10; addr_sel = 3'd4; dst_sel = 4'd4;
    @(negedge clk);
    exp = 20'b1_0_0_100_1_0_0000_0_0_0_0_1_0_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL b2b_t1 got=%b exp=%b", outs, exp); end
    // A request held mid-cycle must not disturb the captured fields.
    cyc_type = 2'b00; addr_sel = 3'd0; dst_sel = 4'd5;
    @(negedge clk);
    exp = 20'b1_0_0_100_0_1_0100_1_0_0_0_0_0_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL b2b_t2 got=%b exp=%b", outs, exp); end
    cyc_type = 2'b11;
    @(negedge clk);
    exp = 20'b1_1_0_100_0_1_0100_1_0_0_0_0_0_0_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL b2b_t3 got=%b exp=%b", outs, exp); end
    @(negedge clk); start = 0;
    exp = 20'b0_0_1_100_0_0_0000_0_0_0_0_0_0_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL b2b_ill_final got=%b exp=%b", outs, exp); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_cycle();
    logic [19:0] exp;
    int nb, nd, ni;
    start = 1; cyc_type = 2'b01; addr_sel = 3'd1; dst_sel = 4'd2; ready = 0;
    @(negedge clk); start = 0;
    repeat (2) @(negedge clk);
    tests++; if (wait_s !== 1'b1) begin fails++; $display("FAIL rst_pre_tw got=%b exp=1", wait_s); end
    rst_n = 0;
    #1;
    exp = 20'b0_0_0_100_0_0_0000_0_0_0_0_0_0_1_0;
    tests++; if (outs !== exp) begin fails++; $display("FAIL rst_async got=%b exp=%b", outs, exp); end
    @(negedge clk);
    rst_n = 1; ready = 1;
    @(negedge clk);
    start = 1; cyc_type = 2'b00; addr_sel = 3'd4;
    nb = 0; nd = 0; ni = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); start = 0;
      if (busy) nb++;
      if (done) nd++;
      if (ir_load) ni++;
      if (!busy) break;
    end
    tests++; if (nb !== 4) begin fails++; $display("FAIL rst_fetch_busy got=%0d exp=4", nb); end
    tests++; if ({nd[3:0], ni[3:0]} !== 8'h11) begin fails++; $display("FAIL rst_fetch_done_ir got=%0d/%0d exp=1/1", nd, ni); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_mem_rd_wait();
    test_mem_wr();
    test_timeout();
    test_illegal();
    test_back_to_back();
    test_reset_mid_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
